// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default sizing, line level.
// UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int DEF_CLKS_PER_BIT = 2;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_FIFO_DEPTH   = 4;

  localparam logic LINE_IDLE = 1'b1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;
`endif

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO with sticky overrun flag.
// A push into a full FIFO is kept only if a pop frees a slot that cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_BITS,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & full & ~do_pop) overrun <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receiver with mid-bit sampling feeding a FWFT byte FIFO.
// Define UART_RX_PARITY_EN for one even-parity bit per frame.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 Ux_reset,
  input  logic                 rx_line,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 fifo_full,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  logic sync1;
  logic rx_s;
  logic rx_q;
  logic fall;

  always_ff @(posedge clk or posedge Ux_reset) begin
    if (Ux_reset) begin
      sync1 <= LINE_IDLE;
      rx_s  <= LINE_IDLE;
      rx_q  <= LINE_IDLE;
    end else begin
      sync1 <= rx_line;
      rx_s  <= sync1;
      rx_q  <= rx_s;
    end
  end

  assign fall = rx_q & ~rx_s;

  uart_state_t          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bits, bits_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 push_n, push_q;
  logic                 ferr_n, ferr_q;
  logic                 tick;
  logic                 empty;

  assign tick = (cnt == CW'(1));

`ifdef UART_RX_PARITY_EN
  logic par_bad, par_bad_n;
  logic perr_n, perr_q;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bits_n  = bits;
    shreg_n = shreg;
    push_n  = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
    perr_n    = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (fall) begin
          cnt_n   = CW'(CLKS_PER_BIT / 2);
          state_n = S_START;
`ifdef UART_RX_PARITY_EN
          par_bad_n = 1'b0;
`endif
        end
      end
      S_START: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (!rx_s) begin
          cnt_n   = CW'(CLKS_PER_BIT);
          bits_n  = '0;
          state_n = S_DATA;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_DATA: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          cnt_n   = CW'(CLKS_PER_BIT);
          bits_n  = bits + 1'b1;
          if (bits == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          par_bad_n = rx_s ^ (^shreg);
          cnt_n     = CW'(CLKS_PER_BIT);
          state_n   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = S_IDLE;
          ferr_n  = ~rx_s;
`ifdef UART_RX_PARITY_EN
          perr_n = par_bad;
          push_n = rx_s & ~par_bad;
`else
          push_n = rx_s;
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Ux_reset) begin
    if (Ux_reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      bits   <= '0;
      shreg  <= '0;
      push_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      bits   <= bits_n;
      shreg  <= shreg_n;
      push_q <= push_n;
      ferr_q <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
      perr_q  <= perr_n;
`endif
    end
  end

  assign frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  // shreg is stable in IDLE/START, so it still holds the byte when push_q fires
  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (Ux_reset),
    .push      (push_q),
    .push_data (shreg),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (empty),
    .overrun   (overrun_err)
  );

  assign rd_valid = ~empty;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed and random frames against a queue model of the receiver.
// Compile with UART_RX_PARITY_EN to exercise the parity bit.
module tb_uart_rx_buffer;

  localparam int CPB   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       Ux_reset;
  logic       rx_line;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       fifo_full;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;

  uart_rx_buffer #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .Ux_reset    (Ux_reset),
    .rx_line     (rx_line),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_full   (fifo_full),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int ferr_exp = 0;
  int perr_exp = 0;
  logic [7:0] q[$];
  logic       ovr_exp = 1'b0;

  always @(negedge clk) begin
    if (frame_err === 1'b1)  ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop);
    rx_line = 1'b1;
    repeat (8) @(negedge clk);
    if (!stop) ferr_exp++;
`ifdef UART_RX_PARITY_EN
    if (par_flip) perr_exp++;
    if (stop && !par_flip) begin
`else
    if (stop) begin
`endif
      if (q.size() < DEPTH) q.push_back(b);
      else ovr_exp = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    e = (q.size() > 0) ? q.pop_front() : 8'h00;
    check({tag, "_data"}, {24'd0, rd_data}, {24'd0, e});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic status(input string tag);
    check({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, q.size() != 0});
    check({tag, "_full"}, {31'd0, fifo_full}, {31'd0, q.size() == DEPTH});
    check({tag, "_ovr"}, {31'd0, overrun_err}, {31'd0, ovr_exp});
    check({tag, "_ferr"}, ferr_cnt, ferr_exp);
    check({tag, "_perr"}, perr_cnt, perr_exp);
  endtask

  initial begin
    Ux_reset = 1'b1;
    rx_line  = 1'b1;
    rd_en    = 1'b0;
    repeat (3) @(negedge clk);
    Ux_reset = 1'b0;
    repeat (20) @(negedge clk);
    status("reset");
    check("reset_data", {24'd0, rd_data}, 32'd0);

    send_frame(8'hA5, 1'b1, 1'b0);
    status("a5");
    pop_check("a5");
    status("a5_popped");

    rx_line = 1'b0;
    @(negedge clk);
    rx_line = 1'b1;
    repeat (12) @(negedge clk);
    status("glitch");

    send_frame(8'h3C, 1'b0, 1'b0);
    status("ferr");
    send_frame(8'h55, 1'b1, 1'b0);
    pop_check("after_ferr");

    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("full4", {31'd0, fifo_full}, 32'd1);
    check("ovr4", {31'd0, overrun_err}, 32'd0);
    send_frame(8'h05, 1'b1, 1'b0);
    status("ovr5");
    for (int i = 1; i <= 4; i++) pop_check("drain");
    status("drained");

    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx_line = 1'b1;
    @(negedge clk);
    Ux_reset = 1'b1;
    @(negedge clk);
    Ux_reset = 1'b0;
    repeat (20) @(negedge clk);
    ovr_exp = 1'b0;
    status("midreset");
    send_frame(8'h81, 1'b1, 1'b0);
    status("after_reset");
    pop_check("x81");
    status("x81_popped");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    status("par_bad");
    send_frame(8'h07, 1'b1, 1'b0);
    pop_check("par_ok");
`endif

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic stop;
      logic pf;
      b    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      pf   = ($urandom_range(0, 7) == 0);
      send_frame(b, stop, pf);
      status("rand");
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        if (q.size() > 0) pop_check("rand_pop");
      end
    end
    while (q.size() > 0) pop_check("final");
    status("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

UART receive front end that consumes the serial stream driven on `Ux_out` by the reconfigurable controller, or any external `Ux_in` source. It synchronises the line, validates the start bit, samples each bit at mid-bit, checks the stop bit, and queues received bytes in a small first-word-fall-through FIFO for the host side. It is the downstream stage of the UART path and gives the bench a self-checking loopback target.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 2: clock cycles per UART bit. Minimum 2. 10 ns clock with 20 ns bit gives 2.
- `DATA_BITS`, default 8: payload bits per frame, LSB first.
- `FIFO_DEPTH`, default 4: byte entries. Must be a power of 2, minimum 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `Ux_reset`  in  1  asynchronous, active-high reset.
- `rx_line`  in  1  serial input; idle high.
- `rd_en`  in  1  pop request; effective only when `rd_valid`=1.
- `rd_data`  out  DATA_BITS  FIFO head byte; valid when `rd_valid`=1.
- `rd_valid`  out  1  FIFO not empty.
- `fifo_full`  out  1  FIFO holds FIFO_DEPTH bytes.
- `frame_err`  out  1  1-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  1-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- `overrun_err`  out  1  sticky: a good byte was dropped because the FIFO was full.

## Operation
- Input path: 2-flop synchroniser on `rx_line`, then a registered copy for falling-edge detect. All sampling uses the synchronised value `rx_s`.
- FSM states are IDLE, START, DATA, PARITY (only with macro), STOP.
  - IDLE: on a falling edge of `rx_s`, load the bit counter with CLKS_PER_BIT/2 (integer division) and go to START.
  - START: when the counter expires, sample `rx_s`. If it is 0, go to DATA. If it is 1 (glitch), return to IDLE with no flags.
  - DATA: take a sample every CLKS_PER_BIT cycles. Shift the bit into the shift register LSB-first. Go to PARITY or STOP after DATA_BITS samples.
  - PARITY: after one bit period, sample and compare against the XOR of the data bits (even parity).
  - STOP: after one bit period, sample. If the stop bit is 1 and there is no parity error, push the byte. If the stop bit is 0, pulse `frame_err` and drop the byte. On a parity error, pulse `parity_err` and drop the byte. In all three cases, return to IDLE.
- A new falling edge is only recognised in IDLE. After a framing error, the line must return high before the next frame.
- FIFO behaviour:
  - Push is accepted when not full. It is also accepted when full and a pop occurs in the same cycle; this does not count as an overrun.
  - A push while full with no pop drops the byte and sets `overrun_err`.
  - `rd_en` while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy count is clog2(FIFO_DEPTH)+1 bits wide.
- Reset values: FSM in IDLE; FIFO empty; `rd_valid`=0, `fifo_full`=0, `rd_data`=0, all error outputs 0. Synchroniser flops reset to 1.
- Reset mid-frame: the partial frame is discarded. No flag is raised after release.

## Timing
- Falling edge on `rx_line` to edge detect: 3 cycles (2 synchroniser cycles plus the edge register).
- Start sample: CLKS_PER_BIT/2 cycles after edge detect.
- Data bit n (n=0..DATA_BITS-1): sampled (n+1)·CLKS_PER_BIT cycles after the start sample.
- Stop sample: one bit period after the last data or parity sample.
- Push occurs on the stop-sample edge. `rd_valid` and `rd_data` are updated on the next edge.
- `frame_err` and `parity_err` are high for exactly the cycle after the stop sample.
- Pop: with `rd_en`=1 and `rd_valid`=1 at edge k, `rd_data` shows the next entry after edge k. `rd_valid` falls after edge k if the FIFO becomes empty.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined: the PARITY state exists; each frame carries one even-parity bit after the data; `parity_err` is live.
- Undefined: no PARITY state; frame is start, data, stop; `parity_err` is tied 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - Default values for CLKS_PER_BIT, DATA_BITS and FIFO_DEPTH.
  - Idle line level constant (1).
  - Shared with the UART transmitter.
- Sub-module `uart_rx_fifo`: synchronous FWFT FIFO with push, pop, full, empty and overrun detection.
- The FSM, synchroniser and bit counter live in the top level.

## Test plan
- Reset, then idle line high for 20 cycles: `rd_valid`=0 and all flags stay 0.
- Send 0xA5 at CLKS_PER_BIT=2: `rd_valid` rises 1 cycle after the stop sample with `rd_data`=0xA5. Pulse `rd_en` once: `rd_valid`=0.
- Drive `rx_line` low for 1 cycle, then high: no byte is queued and no flag is raised.
- Send 0x3C with the stop bit driven 0: one `frame_err` pulse, FIFO stays empty. Then send 0x55 normally: `rd_data`=0x55.
- Send 0x01, 0x02, 0x03, 0x04, 0x05 with no reads: `fifo_full`=1 after the 4th byte and `overrun_err`=1 after the 5th. Reads return 0x01..0x04.
- Assert `Ux_reset` during data bit 3 of 0xFF, release, then send 0x81: the only byte queued is 0x81.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0: `parity_err` pulses and no push. Resend 0x07 with parity bit 1: `rd_data`=0x07.
